// File: rtl/rom_add_sequencer_pkg.sv
// rom_add_sequencer_pkg: shared state encoding and default sizes for the ROM-add sequencer
package rom_add_sequencer_pkg;
    localparam int ADDR_W_DEF  = 3;
    localparam int DATA_W_DEF  = 8;
    localparam int ELEM_CYCLES = 4;
    typedef enum logic [2:0] {IDLE, RD1, RD2, ADD, WR, DONE} state_t;
endpackage

// File: rtl/rom_add_alu.sv
// rom_add_alu: captures the first ROM operand and registers its sum with the second
// Ports: clk, rst (active-low async), cap_a (load op_a from rom_data),
//        do_add (load sum from op_a + rom_data), rom_data, sum (registered).
// Optional: ROM_ADD_SATURATE_EN clamps an overflowing sum to all-ones instead of wrapping.
module rom_add_alu #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_a,
    input  logic              do_add,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sum
);
    logic [DATA_W-1:0] op_a, sum_n;
`ifdef ROM_ADD_SATURATE_EN
    logic [DATA_W:0] full;
    assign full  = {1'b0, op_a} + {1'b0, rom_data};
    assign sum_n = full[DATA_W] ? '1 : full[DATA_W-1:0];
`else
    assign sum_n = op_a + rom_data;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a <= '0;
            sum  <= '0;
        end else begin
            if (cap_a) op_a <= rom_data;
            if (do_add) sum <= sum_n;
        end
    end
endmodule

// File: rtl/rom_add_sequencer.sv
// rom_add_sequencer: walks N ROM operand pairs, adds them and writes the sums to RAM
// Ports: clk, rst (active-low async), start/count/base1/base2/base_ram (job request,
//        latched at start), rom_addr/rom_data (ROM read port, 1-cycle latency),
//        ram_addr/ram_we/ram_wdata (RAM write port), result (last sum written),
//        busy, done (one-cycle end-of-job pulse).
// Optional: ROM_ADD_SATURATE_EN (see rom_add_alu) saturates the sum.
module rom_add_sequencer
    import rom_add_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   count,
    input  logic [ADDR_W-1:0] base1,
    input  logic [ADDR_W-1:0] base2,
    input  logic [ADDR_W-1:0] base_ram,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(1) << ADDR_W;
    state_t            state, nxt;
    logic [ADDR_W:0]   cnt_r;
    logic [ADDR_W-1:0] i_r, b1_r, b2_r, br_r, rom_addr_q, ram_addr_q;
    logic [DATA_W-1:0] sum_r, wdata_q, result_r;
    logic              last;
    assign last = {1'b0, i_r} == (cnt_r - 1'b1);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !start ? IDLE : (count == '0) ? DONE : RD1;
            RD1:     nxt = RD2;
            RD2:     nxt = ADD;
            ADD:     nxt = WR;
            WR:      nxt = last ? DONE : RD1;
            default: nxt = IDLE;
        endcase
    end
    // Address/data outputs are decoded from state and fall back to a copy of
    // their previous value so they hold outside the phases that drive them.
    assign rom_addr  = (state == RD1) ? b1_r + i_r : (state == RD2) ? b2_r + i_r : rom_addr_q;
    assign ram_we    = state == WR;
    assign ram_addr  = ram_we ? br_r + i_r : ram_addr_q;
    assign ram_wdata = ram_we ? sum_r : wdata_q;
    assign result    = result_r;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt_r      <= '0;
            i_r        <= '0;
            b1_r       <= '0;
            b2_r       <= '0;
            br_r       <= '0;
            rom_addr_q <= '0;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            result_r   <= '0;
        end else begin
            state      <= nxt;
            rom_addr_q <= rom_addr;
            ram_addr_q <= ram_addr;
            wdata_q    <= ram_wdata;
            if (state == IDLE && start && count != '0) begin
                cnt_r <= (count > MAX_CNT) ? MAX_CNT : count;
                b1_r  <= base1;
                b2_r  <= base2;
                br_r  <= base_ram;
                i_r   <= '0;
            end
            if (state == WR) begin
                result_r <= sum_r;
                if (!last) i_r <= i_r + 1'b1;
            end
        end
    end
    rom_add_alu #(.DATA_W(DATA_W)) u_alu (
        .clk      (clk),
        .rst      (rst),
        .cap_a    (state == RD2),
        .do_add   (state == ADD),
        .rom_data (rom_data),
        .sum      (sum_r)
    );
endmodule
